// File: rtl/sram_bus_arbiter_if.sv
// Bundle of the two requester ports and the shared memory port seen by the arbiter.
interface sram_bus_arbiter_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    modport slave (
        input  inst_req, inst_addr,
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output mem_req, mem_wr, mem_size, mem_addr, mem_wdata
    );

    modport master (
        output inst_req, inst_addr,
        output data_req, data_wr, data_size, data_addr, data_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  mem_req, mem_wr, mem_size, mem_addr, mem_wdata
    );
endinterface

// File: rtl/sram_bus_arbiter.sv
// Shares one sram-like memory port between instruction fetch and data access,
// one outstanding transaction at a time.
module sram_bus_arbiter #(
    parameter int PRIO_MODE = 0
) (
    input logic               clk,
    input logic               reset,
    sram_bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t      state, state_nxt;
    logic        owner, last_owner;
    logic        wr_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q;
    logic        grant_inst, grant_data, done;

    // Handshake strobes are gated by reset so an aborted transaction never completes.
    always_comb begin
        state_nxt  = state;
        grant_inst = 1'b0;
        grant_data = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: if (!reset) begin
                grant_data = bus.data_req &&
                             (!bus.inst_req || PRIO_MODE == 0 || !last_owner);
                grant_inst = bus.inst_req && !grant_data;
                if (grant_data || grant_inst) state_nxt = REQ;
            end
            REQ:  if (bus.mem_addr_ok) state_nxt = RESP;
            RESP: if (bus.mem_data_ok && !reset) begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b0;
            wr_q       <= 1'b0;
            size_q     <= 2'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
        end else begin
            state <= state_nxt;
            if (grant_data) begin
                owner   <= 1'b1;
                wr_q    <= bus.data_wr;
                size_q  <= bus.data_size;
                addr_q  <= bus.data_addr;
                wdata_q <= bus.data_wdata;
            end else if (grant_inst) begin
                owner   <= 1'b0;
                wr_q    <= 1'b0;
                size_q  <= 2'd2;
                addr_q  <= bus.inst_addr;
                wdata_q <= 32'd0;
            end
            if (done) last_owner <= owner;
        end
    end

    assign bus.inst_addr_ok = grant_inst;
    assign bus.data_addr_ok = grant_data;
    assign bus.inst_data_ok = done && !owner;
    assign bus.data_data_ok = done && owner;
    assign bus.inst_rdata   = bus.mem_rdata;
    assign bus.data_rdata   = bus.mem_rdata;

    assign bus.mem_req   = (state == REQ) && !reset;
    assign bus.mem_wr    = wr_q;
    assign bus.mem_size  = size_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Randomized transaction-level check of sram_bus_arbiter; DUT 0 uses fixed data
// priority, DUT 1 round-robin.
module tb_sram_bus_arbiter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [1:0]  inst_req, data_req, data_wr, mem_addr_ok, mem_data_ok;
    logic [31:0] inst_addr [2];
    logic [31:0] data_addr [2];
    logic [31:0] data_wdata [2];
    logic [31:0] mem_rdata [2];
    logic [1:0]  data_size [2];
    logic [1:0]  inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, mem_req, mem_wr;
    logic [31:0] inst_rdata [2];
    logic [31:0] data_rdata [2];
    logic [31:0] mem_addr [2];
    logic [31:0] mem_wdata [2];
    logic [1:0]  mem_size [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        sram_bus_arbiter_if bus ();
        assign bus.inst_req    = inst_req[g];
        assign bus.inst_addr   = inst_addr[g];
        assign bus.data_req    = data_req[g];
        assign bus.data_wr     = data_wr[g];
        assign bus.data_size   = data_size[g];
        assign bus.data_addr   = data_addr[g];
        assign bus.data_wdata  = data_wdata[g];
        assign bus.mem_addr_ok = mem_addr_ok[g];
        assign bus.mem_data_ok = mem_data_ok[g];
        assign bus.mem_rdata   = mem_rdata[g];
        assign inst_addr_ok[g] = bus.inst_addr_ok;
        assign inst_data_ok[g] = bus.inst_data_ok;
        assign inst_rdata[g]   = bus.inst_rdata;
        assign data_addr_ok[g] = bus.data_addr_ok;
        assign data_data_ok[g] = bus.data_data_ok;
        assign data_rdata[g]   = bus.data_rdata;
        assign mem_req[g]      = bus.mem_req;
        assign mem_wr[g]       = bus.mem_wr;
        assign mem_size[g]     = bus.mem_size;
        assign mem_addr[g]     = bus.mem_addr;
        assign mem_wdata[g]    = bus.mem_wdata;

        sram_bus_arbiter #(.PRIO_MODE(g)) dut (.clk(clk), .reset(reset), .bus(bus));
    end

    int tests = 0;
    int fails = 0;

    // Reference state: pending requests held by each requester, and who owned the last completion.
    bit          ipend, dpend;
    logic [31:0] i_a, d_a, d_wd;
    logic        d_wr;
    logic [1:0]  d_sz;
    logic [1:0]  last_own;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int k);
        inst_req      = '0;
        data_req      = '0;
        inst_req[k]   = ipend;
        inst_addr[k]  = i_a;
        data_req[k]   = dpend;
        data_wr[k]    = d_wr;
        data_size[k]  = d_sz;
        data_addr[k]  = d_a;
        data_wdata[k] = d_wd;
    endtask

    task automatic idle_cycle(input int k, input bit spur);
        drive(k);
        mem_addr_ok[k] = spur;
        mem_data_ok[k] = spur;
        mem_rdata[k]   = $urandom;
        @(negedge clk);
        chk("idle_quiet", {mem_req[k], inst_addr_ok[k], data_addr_ok[k], inst_data_ok[k], data_data_ok[k]}, 64'd0);
        @(posedge clk); #1;
        mem_addr_ok[k] = 1'b0;
        mem_data_ok[k] = 1'b0;
    endtask

    // One complete transaction: grant, d1 stall cycles before mem_addr_ok, d2 before mem_data_ok.
    task automatic do_round(input int k, input int d1, input int d2, input logic [31:0] rd, input bit abort);
        bit          win_d, is_wr, last;
        logic [34:0] exp_f;
        logic [31:0] exp_wd;
        win_d  = dpend && (!ipend || k == 0 || !last_own[k]);
        is_wr  = win_d && d_wr;
        exp_f  = win_d ? {d_wr, d_sz, d_a} : {1'b0, 2'd2, i_a};
        exp_wd = d_wd;

        drive(k);
        mem_addr_ok[k] = 1'b0;
        mem_data_ok[k] = 1'b0;
        @(negedge clk);
        chk("grant", {inst_addr_ok[k], data_addr_ok[k], mem_req[k], inst_data_ok[k], data_data_ok[k]},
            {59'd0, !win_d, win_d, 3'b000});
        @(posedge clk); #1;
        if (win_d) begin
            dpend = 1'b0; d_a = $urandom; d_wd = $urandom;
        end else begin
            ipend = 1'b0; i_a = $urandom;
        end
        drive(k);

        for (int i = 0; i <= d1; i++) begin
            mem_addr_ok[k] = (i == d1);
            mem_data_ok[k] = ($urandom_range(0, 3) == 0);
            mem_rdata[k]   = $urandom;
            @(negedge clk);
            chk("req_phase", {mem_req[k], inst_addr_ok[k], data_addr_ok[k], inst_data_ok[k], data_data_ok[k]}, 64'b10000);
            chk("mem_fields", {mem_wr[k], mem_size[k], mem_addr[k]}, {29'd0, exp_f});
            if (is_wr) chk("mem_wdata", mem_wdata[k], exp_wd);
            @(posedge clk); #1;
        end

        for (int i = 0; i <= d2; i++) begin
            last           = (i == d2);
            mem_data_ok[k] = last;
            mem_addr_ok[k] = ($urandom_range(0, 3) == 0);
            mem_rdata[k]   = last ? rd : $urandom;
            if (last && abort) begin
                reset = 1'b1; ipend = 1'b0; dpend = 1'b0;
                drive(k);
            end
            @(negedge clk);
            if (last && abort) begin
                chk("abort", {mem_req[k], inst_addr_ok[k], data_addr_ok[k], inst_data_ok[k], data_data_ok[k]}, 64'd0);
            end else begin
                chk("resp_phase", {mem_req[k], inst_addr_ok[k], data_addr_ok[k], inst_data_ok[k], data_data_ok[k]},
                    {59'd0, 3'b000, last && !win_d, last && win_d});
                if (last && !is_wr) chk("rdata", win_d ? data_rdata[k] : inst_rdata[k], rd);
            end
            @(posedge clk); #1;
        end
        mem_addr_ok[k] = 1'b0;
        mem_data_ok[k] = 1'b0;
        if (abort) begin
            reset    = 1'b0;
            last_own = '0;
        end else begin
            last_own[k] = win_d;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        inst_req = '0; data_req = '0; data_wr = '0; mem_addr_ok = '0; mem_data_ok = '0;
        for (int k = 0; k < 2; k++) begin
            inst_addr[k] = '0; data_addr[k] = '0; data_wdata[k] = '0;
            mem_rdata[k] = '0; data_size[k] = '0;
        end
        ipend = 0; dpend = 0; i_a = '0; d_a = '0; d_wd = '0; d_wr = 0; d_sz = '0;
        last_own = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("reset_state", {mem_req[k], mem_wr[k], mem_size[k], mem_addr[k], inst_addr_ok[k],
                data_addr_ok[k], inst_data_ok[k], data_data_ok[k]}, 64'd0);
            chk("reset_wdata", mem_wdata[k], 64'd0);
        end
        @(posedge clk); #1;
        reset = 1'b0;

        // Lone instruction fetch with minimum latency.
        ipend = 1; i_a = 32'hbfc00000;
        do_round(0, 0, 0, 32'h3c1d0000, 0);

        // Tie under fixed priority: data first, then the held instruction request.
        ipend = 1; i_a = 32'hbfc00004;
        dpend = 1; d_wr = 0; d_sz = 2'd2; d_a = 32'h80001000; d_wd = 32'h0;
        do_round(0, 0, 1, 32'h12345678, 0);
        do_round(0, 0, 0, 32'h9abcdef0, 0);

        // Byte write held across a three-cycle memory stall.
        dpend = 1; d_wr = 1; d_sz = 2'd0; d_a = 32'h80000003; d_wd = 32'h000000ab;
        do_round(0, 3, 0, 32'hdeadbeef, 0);

        // Spurious responses while idle must not disturb the next grant.
        idle_cycle(0, 1);
        ipend = 1; i_a = 32'hbfc00010;
        do_round(0, 0, 0, 32'h0badf00d, 0);

        // Reset while waiting for data, with mem_data_ok landing in the reset cycle.
        ipend = 1; i_a = 32'hbfc00020;
        do_round(0, 1, 2, 32'h55aa55aa, 1);
        @(negedge clk);
        chk("post_reset", {mem_req[0], mem_wr[0], mem_size[0], mem_addr[0], inst_data_ok[0], data_data_ok[0]}, 64'd0);
        @(posedge clk); #1;
        ipend = 1; i_a = 32'hbfc00024;
        do_round(0, 0, 0, 32'h11112222, 0);

        // Round-robin with both requesters held: data, inst, data, inst.
        for (int n = 0; n < 4; n++) begin
            if (!ipend) begin ipend = 1; i_a = 32'hbfc00100 + 32'(n * 4); end
            if (!dpend) begin dpend = 1; d_wr = 0; d_sz = 2'd2; d_a = 32'h80002000 + 32'(n * 4); end
            do_round(1, 0, 0, $urandom, 0);
        end
        while (ipend || dpend) do_round(1, 0, 0, $urandom, 0);

        for (int k = 0; k < 2; k++) begin
            for (int n = 0; n < 80; n++) begin
                if (!ipend && $urandom_range(0, 1) == 1) begin
                    ipend = 1; i_a = $urandom & 32'hfffffffc;
                end
                if (!dpend && $urandom_range(0, 1) == 1) begin
                    dpend = 1; d_wr = $urandom_range(0, 1) == 1; d_sz = 2'($urandom_range(0, 2));
                    d_a = $urandom; d_wd = $urandom;
                end
                if (!ipend && !dpend) idle_cycle(k, $urandom_range(0, 1) == 1);
                else do_round(k, $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
                              $urandom_range(0, 19) == 0);
            end
            while (ipend || dpend) do_round(k, 0, 0, $urandom, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
